// File: rtl/uk101_pkg.sv
// Shared definitions for the UK101 text loader: FSM states, ASCII control codes
// and the serial character timing helper.
package uk101_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESENT  = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_GAP      = 2'd3
  } ldr_state_e;

  localparam logic [7:0]  ASCII_CR      = 8'h0D;
  localparam logic [7:0]  ASCII_LF      = 8'h0A;
  localparam int unsigned BITS_PER_CHAR = 10;

  // Clock cycles occupied by one start+8+stop character at the given baud rate.
  function automatic int unsigned char_cycles(input int unsigned clk_hz,
                                              input int unsigned baud);
    return (BITS_PER_CHAR * clk_hz) / baud;
  endfunction

endpackage

// File: rtl/ascii_loader_fifo.sv
// Byte FIFO for the text loader. A flush empties it; a push in the flush cycle
// becomes the first entry of the fresh buffer. Pushes while full are dropped.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & (flush_i | ~full_o);
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign wr_idx  = flush_i ? '0 : wr_ptr_q;

  always_comb begin
    if (flush_i) begin
      wr_ptr_d = AW'(push_ok);
      rd_ptr_d = '0;
      count_d  = (AW+1)'(push_ok);
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/ascii_loader.sv
// Paces a downloaded text file into the ACIA receive path one byte at a time,
// leaving a character time between bytes and a longer pause after each CR.
module ascii_loader
  import uk101_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int FIFO_DEPTH   = 16,
  parameter int CR_GAP_CHARS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_data,
  output logic       ioctl_wait,
  input  logic       baud_rate,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned CHAR_FAST = char_cycles(CLK_HZ, 9600);
  localparam int unsigned CHAR_SLOW = char_cycles(CLK_HZ, 300);
  localparam int unsigned CR_MULT   = 1 + CR_GAP_CHARS;
  localparam int unsigned GAP_MAX   = CHAR_SLOW * CR_MULT;
  localparam int          GW        = $clog2(GAP_MAX + 1);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

  ldr_state_e    state_q, state_d;
  logic [7:0]    rx_data_q, rx_data_d, fifo_dout;
  logic          rx_valid_q, rx_valid_d;
  logic [GW-1:0] gap_q, gap_d, gap_load;
  logic          dl_q, dl_rise, wait_q, ovf_q, ovf_d;
  logic          push_req, pop, ack_ok, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, fifo_count_next;
  int unsigned   gap_len;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign push_req = ioctl_download & ioctl_wr & (ioctl_data != ASCII_LF);
  assign ack_ok   = rx_ack & rx_valid_q;
  assign ovf_d    = dl_rise ? 1'b0 : (ovf_q | (push_req & fifo_full));

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (reset),
    .flush_i      (dl_rise),
    .push_i       (push_req),
    .din_i        (ioctl_data),
    .pop_i        (pop),
    .dout_o       (fifo_dout),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .count_next_o (fifo_count_next)
  );

  // Baud rate is sampled only when a gap is loaded, so a change mid-gap waits for the next byte.
  always_comb begin
    gap_len = baud_rate ? CHAR_SLOW : CHAR_FAST;
    if (rx_data_q == ASCII_CR) gap_len = gap_len * CR_MULT;
    gap_load = GW'(gap_len - 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      gap_q      <= '0;
      dl_q       <= 1'b0;
      wait_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      gap_q      <= gap_d;
      dl_q       <= ioctl_download;
      wait_q     <= (fifo_count_next >= CW'(FIFO_DEPTH - 2));
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (dl_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (!fifo_empty) state_d = ST_PRESENT;
        ST_PRESENT:  state_d = ST_WAIT_ACK;
        ST_WAIT_ACK: if (ack_ok) state_d = ST_GAP;
        ST_GAP:      if (gap_q == '0) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pop        = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    gap_d      = gap_q;
    if (dl_rise) begin
      rx_valid_d = 1'b0;
      gap_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            rx_data_d = fifo_dout;
          end
        end
        ST_PRESENT:  rx_valid_d = 1'b1;
        ST_WAIT_ACK: begin
          if (ack_ok) begin
            rx_valid_d = 1'b0;
            gap_d      = gap_load;
          end
        end
        ST_GAP:      if (gap_q != '0) gap_d = gap_q - GW'(1);
        default:     ;
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign ioctl_wait = wait_q;
  assign overflow   = ovf_q;
  assign busy       = ~reset & (ioctl_download | (fifo_count != '0) | (state_q != ST_IDLE));

endmodule

// File: doc/ascii_loader.md
ASCII_LOADER -- requirements
Module: ascii_loader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clk frequency in Hz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte buffer entries (power of two, >=4).
REQ-003 SHALL have parameter CR_GAP_CHARS, default 16, extra character times inserted after a CR.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 ioctl_download  input  1  high while the HPS transfers a TXT file.
REQ-007 ioctl_wr  input  1  one-cycle strobe; ioctl_data valid.
REQ-008 ioctl_data  input  8  downloaded ASCII byte.
REQ-009 ioctl_wait  output  1  backpressure to the HPS; no ioctl_wr is expected the cycle after it is sampled high.
REQ-010 baud_rate  input  1  0 = 9600, 1 = 300; selects pacing.
REQ-011 rx_data  output  8  byte offered to the ACIA receive path.
REQ-012 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-013 rx_ack  input  1  one-cycle pulse: ACIA has taken rx_data.
REQ-014 busy  output  1  a load is in progress; drives LED_USER.
REQ-015 overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Function
REQ-016 Each ioctl_wr with ioctl_download high SHALL push ioctl_data into the FIFO, except byte 0x0A (LF), which SHALL be discarded.
REQ-017 ioctl_wr with ioctl_download low SHALL be ignored.
REQ-018 ioctl_wait SHALL be high, registered, whenever FIFO count >= FIFO_DEPTH-2.
REQ-019 A push while the FIFO is full SHALL drop the byte and set overflow; overflow clears only on reset or the rising edge of ioctl_download.
REQ-020 CHAR = 10*CLK_HZ/9600 cycles when baud_rate=0 and 10*CLK_HZ/300 when baud_rate=1, evaluated with integer arithmetic; the pacing counter SHALL be wide enough for the 300-baud value.
REQ-021 The FSM SHALL have states IDLE, PRESENT, WAIT_ACK and GAP.
REQ-022 IDLE -> PRESENT when the FIFO is non-empty: pop one byte into rx_data; rx_valid rises the following cycle.
REQ-023 PRESENT/WAIT_ACK: rx_valid stays high and rx_data stable until rx_ack; on rx_ack, rx_valid falls the next cycle, and the FSM loads the gap counter and enters GAP.
REQ-024 The gap SHALL be CHAR cycles, or CHAR*(1+CR_GAP_CHARS) cycles if the byte was 0x0D; GAP -> IDLE when the counter reaches zero.
REQ-025 rx_ack while rx_valid is low SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL both take effect; count is unchanged.
REQ-027 A baud_rate change SHALL affect only gaps loaded after the change.
REQ-028 busy SHALL be high while ioctl_download is high, the FIFO is non-empty, or the state is not IDLE.
REQ-029 A rising edge of ioctl_download SHALL flush the FIFO and return the FSM to IDLE with rx_valid low, abandoning any byte in flight.
REQ-030 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-031 On reset the FIFO SHALL be empty, the state IDLE, and the gap counter 0.
REQ-032 On reset all outputs SHALL be 0: rx_data=0x00, rx_valid, ioctl_wait, busy and overflow low.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered bytes, with no partial byte presented after release.

Structure
REQ-034 A shared package uk101_pkg SHALL hold the FSM state enum, ASCII_CR=8'h0D, ASCII_LF=8'h0A and BITS_PER_CHAR=10.
REQ-035 The FIFO SHALL be a sub-module named byte_fifo (push, pop, full, empty, count), instantiated once.
REQ-036 The emu top SHALL connect ascii_loader between hps_io ioctl and the uk101 serial-receive input when loadFrom selects File.

Verification (bench uses CLK_HZ=96000, so CHAR=100 cycles at 9600 and 3200 at 300)
REQ-037 Download "10 PRINT 1\r\n" with rx_ack one cycle after each rx_valid -> 11 bytes delivered (LF dropped), consecutive rx_valid rises at least 100 cycles apart, and at least 1700 cycles after the 0x0D.
REQ-038 Push 20 bytes back-to-back with no rx_ack -> ioctl_wait high from count 14; with wait honoured, no drop and overflow=0; with wait ignored, overflow=1 and exactly 16 bytes are retained.
REQ-039 Set baud_rate=1, send 0x41 then 0x42 -> the second rx_valid rises no sooner than 3200 cycles after the first ack.
REQ-040 Assert reset while the 3rd of 5 bytes is presented -> all outputs 0 within the same cycle; after release, busy=0 and rx_valid stays 0.
REQ-041 Start a new download while a byte is in GAP -> FIFO flushed, the first byte of the new file is presented next, and overflow is cleared.
